gen_wr_arbiter: RTL

GEN_WR_ARBITER -- requirements
Module: gen_wr_arbiter

---
 rtl/gen_wr_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gen_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gen_wr_arbiter
// Description : Four-way round-robin write arbiter for a gen register block.
//               A granted requester's data is written with a one-cycle
//               active-low strobe. After a settle delay the register is read
//               back and compared. The requester then receives a one-cycle
//               ack. A readback mismatch sets a sticky error flag and
//               records the offending requester.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_wr_arbiter #(
    parameter int bus_width = 15,   // MSB index of the data bus
    parameter int SETTLE    = 2     // settle cycles before readback, 1..15
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic [3:0]                   req,
    input  logic [4*(bus_width+1)-1:0]   wdata,
    input  logic                         err_clr,
    input  logic [bus_width:0]           rdout,
    output logic                         wrb,
    output logic [bus_width:0]           din,
    output logic [3:0]                   ack,
    output logic                         busy,
    output logic                         err,
    output logic [1:0]                   err_src
);

    localparam int         c_DW          = bus_width + 1;
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_SETTLE = 2'd2,
        S_CHECK  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [1:0]        ptr_q,     ptr_d;
    logic [1:0]        gnt_q,     gnt_d;
    logic [3:0]        cnt_q,     cnt_d;
    logic              wrb_q,     wrb_d;
    logic [c_DW-1:0]   din_q,     din_d;
    logic [3:0]        ack_q,     ack_d;
    logic              busy_q,    busy_d;
    logic              err_q,     err_d;
    logic [1:0]        err_src_q, err_src_d;

    logic [c_DW-1:0]   w_slot [4];
    logic              w_found;
    logic [1:0]        w_pick;
    logic [1:0]        w_cand;

    // Split the packed write-data bus into one word per requester
    generate
        for (genvar g = 0; g < 4; g++) begin : g_slot
            assign w_slot[g] = wdata[g*c_DW +: c_DW];
        end
    endgenerate

    // Round-robin search: the first set req bit at or above ptr, wrapping mod 4.
    // The loop walks downward, so the candidate closest to ptr is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = ptr_q;
        w_cand  = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            w_cand = ptr_q + 2'(k);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next-state and registered-output logic for the write/settle/check sequence
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        wrb_d     = 1'b1;
        din_d     = din_q;
        ack_d     = 4'b0000;
        err_d     = err_q;
        err_src_d = err_src_q;

        // A mismatch detected later in this block overrides the clear
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_WRITE;
                    gnt_d   = w_pick;
                    ptr_d   = w_pick + 2'd1;
                    din_d   = w_slot[w_pick];
                    wrb_d   = 1'b0;
                end
            end
            S_WRITE: begin
                state_d = S_SETTLE;
                cnt_d   = 4'd0;
            end
            S_SETTLE: begin
                if (cnt_q == c_SETTLE_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = 4'd0;
                    ack_d   = 4'b0001 << gnt_q;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                // din_q still holds the latched word, so it serves as the reference
                if (rdout != din_q) begin
                    err_d     = 1'b1;
                    err_src_d = gnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 2'd0;
            cnt_q     <= 4'd0;
            wrb_q     <= 1'b1;
            din_q     <= '0;
            ack_q     <= 4'b0000;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_src_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            wrb_q     <= wrb_d;
            din_q     <= din_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
        end
    end

    assign wrb     = wrb_q;
    assign din     = din_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign err_src = err_src_q;

endmodule
`default_nettype wire
